// File: rtl/alu_share_arb_pkg.sv
// Shared ALU definitions: op codes, arbiter FSM encodings and the legality check
// used by the shared ALU and its front end.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// One requester channel of the shared ALU: request handshake carrying operands
// and op code, response handshake carrying result, zero flag and error flag.
interface alu_share_arb_if #(parameter int WIDTH = 32);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] z;
  logic             zero;
  logic             err;

  modport master (
    output req_valid, a, b, op, rsp_ready,
    input  req_ready, rsp_valid, z, zero, err
  );

  modport slave (
    input  req_valid, a, b, op, rsp_ready,
    output req_ready, rsp_valid, z, zero, err
  );

endinterface

// File: rtl/alu_share_arb_yalu.sv
// The datapath's shared combinational ALU. Illegal op codes produce a zero
// result with the error flag raised.
module yAlu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             err
);

  always_comb begin
    z   = '0;
    err = !is_legal_op(op);
    case (op)
      ALU_AND: z = a & b;
      ALU_OR:  z = a | b;
      ALU_ADD: z = a + b;
      ALU_SUB: z = a - b;
      ALU_SLT: z = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: z = '0;
    endcase
  end

  assign zero = (z == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin front end that lets two requesters share one yAlu; one operation
// is in flight at a time and its result is held until the owner takes it.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  alu_share_arb_if.slave req0,
  alu_share_arb_if.slave req1,
  output logic           busy
);

  logic [1:0]       state;
  logic             last;
  logic             owner;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] z_q;
  logic             zero_q;
  logic             err_q;

  logic [WIDTH-1:0] alu_z;
  logic             alu_zero;
  logic             alu_err;
  logic             grant0;
  logic             grant1;
  logic             rsp_take;

  // On a tie the requester that was not served last wins.
  assign grant0 = req0.req_valid && (!req1.req_valid || last);
  assign grant1 = req1.req_valid && (!req0.req_valid || !last);

  assign req0.req_ready = !reset && (state == ST_IDLE) && grant0;
  assign req1.req_ready = !reset && (state == ST_IDLE) && grant1;

  assign req0.rsp_valid = (state == ST_RESP) && !owner;
  assign req1.rsp_valid = (state == ST_RESP) && owner;
  assign req0.z         = z_q;
  assign req1.z         = z_q;
  assign req0.zero      = zero_q;
  assign req1.zero      = zero_q;
  assign req0.err       = err_q;
  assign req1.err       = err_q;

  assign rsp_take = owner ? req1.rsp_ready : req0.rsp_ready;
  assign busy     = (state != ST_IDLE);

  yAlu #(.WIDTH(WIDTH)) u_alu (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .z    (alu_z),
    .zero (alu_zero),
    .err  (alu_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      last   <= 1'b1;
      owner  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      z_q    <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            owner <= grant1;
            a_q   <= grant1 ? req1.a  : req0.a;
            b_q   <= grant1 ? req1.b  : req0.b;
            op_q  <= grant1 ? req1.op : req0.op;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          z_q    <= alu_z;
          zero_q <= alu_zero;
          err_q  <= alu_err;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_take) begin
            last  <= owner;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: table of single operations plus hand-written
// sequences for arbitration, backpressure and mid-operation reset.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   assertions = 0;
  int   failures = 0;

  typedef struct {
    bit          sel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  alu_share_arb_if #(.WIDTH(32)) ch0 ();
  alu_share_arb_if #(.WIDTH(32)) ch1 ();

  alu_share_arb #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (ch0),
    .req1  (ch1),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic rdy(input bit sel);
    return sel ? ch1.req_ready : ch0.req_ready;
  endfunction

  function automatic logic rvld(input bit sel);
    return sel ? ch1.rsp_valid : ch0.rsp_valid;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Full transaction on one channel with rsp_ready held high; bounded waits.
  task automatic applyStimulus(input bit sel, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_z,
                               input logic exp_zero, input logic exp_err, input string name);
    int n;
    @(negedge clk);
    if (sel) begin
      ch1.req_valid = 1'b1; ch1.a = a; ch1.b = b; ch1.op = op;
    end else begin
      ch0.req_valid = 1'b1; ch0.a = a; ch0.b = b; ch0.op = op;
    end
    #1;
    n = 0;
    while (!rdy(sel) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checkOutput({name, " accept"}, 32'(rdy(sel)), 32'd1);
    @(posedge clk); #1;
    ch0.req_valid = 1'b0;
    ch1.req_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!rvld(sel) && n < 20) begin
      @(negedge clk); n++;
    end
    checkOutput({name, " rsp_valid"}, 32'(rvld(sel)), 32'd1);
    checkOutput({name, " other rsp_valid"}, 32'(rvld(!sel)), 32'd0);
    checkOutput({name, " z"}, sel ? ch1.z : ch0.z, exp_z);
    checkOutput({name, " zero"}, 32'(sel ? ch1.zero : ch0.zero), 32'(exp_zero));
    checkOutput({name, " err"}, 32'(sel ? ch1.err : ch0.err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    int   n;
    logic exp_owner;

    reset = 1'b1;
    ch0.req_valid = 1'b0; ch0.a = '0; ch0.b = '0; ch0.op = '0; ch0.rsp_ready = 1'b1;
    ch1.req_valid = 1'b0; ch1.a = '0; ch1.b = '0; ch1.op = '0; ch1.rsp_ready = 1'b1;

    // Reset state, with a request pending that must not be granted yet.
    @(negedge clk);
    ch0.req_valid = 1'b1;
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset req0_ready", 32'(ch0.req_ready), 32'd0);
    checkOutput("reset rsp0_valid", 32'(ch0.rsp_valid), 32'd0);
    checkOutput("reset rsp1_valid", 32'(ch1.rsp_valid), 32'd0);
    checkOutput("reset z", ch0.z, 32'd0);
    checkOutput("reset zero", 32'(ch0.zero), 32'd0);
    checkOutput("reset err", 32'(ch0.err), 32'd0);
    ch0.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Single ADD with exact latency.
    @(negedge clk);
    ch0.req_valid = 1'b1; ch0.a = 32'd5; ch0.b = 32'd7; ch0.op = ALU_ADD;
    #1;
    checkOutput("add ready0", 32'(ch0.req_ready), 32'd1);
    checkOutput("add ready1", 32'(ch1.req_ready), 32'd0);
    @(posedge clk); #1;
    ch0.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("add exec busy", 32'(busy), 32'd1);
    checkOutput("add exec rsp0_valid", 32'(ch0.rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("add rsp0_valid", 32'(ch0.rsp_valid), 32'd1);
    checkOutput("add z", ch0.z, 32'd12);
    checkOutput("add zero", 32'(ch0.zero), 32'd0);
    checkOutput("add rsp1_valid", 32'(ch1.rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Both valid from reset: requester 0 first, then strict alternation.
    applyReset();
    @(negedge clk);
    ch0.req_valid = 1'b1; ch0.a = 32'd9;    ch0.b = 32'd9;    ch0.op = ALU_SUB;
    ch1.req_valid = 1'b1; ch1.a = 32'hF0;   ch1.b = 32'h0F;   ch1.op = ALU_OR;
    exp_owner = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n = 0;
      while (!(ch0.req_ready || ch1.req_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      checkOutput($sformatf("tie grant %0d", i), 32'({ch1.req_ready, ch0.req_ready}),
                  exp_owner ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      if (i == 7) begin
        ch0.req_valid = 1'b0;
        ch1.req_valid = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      checkOutput($sformatf("tie rsp_valid %0d", i), 32'({ch1.rsp_valid, ch0.rsp_valid}),
                  exp_owner ? 32'd2 : 32'd1);
      checkOutput($sformatf("tie z %0d", i), exp_owner ? ch1.z : ch0.z,
                  exp_owner ? 32'hFF : 32'd0);
      checkOutput($sformatf("tie zero %0d", i), 32'(exp_owner ? ch1.zero : ch0.zero),
                  exp_owner ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      exp_owner = !exp_owner;
    end

    // Table of single operations with hand-computed results.
    vecs[0]  = '{1'b1, ALU_SLT, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, ALU_SLT, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
    vecs[2]  = '{1'b0, 3'b100,  32'd12,       32'd34,       32'd0,        1'b1, 1'b1};
    vecs[3]  = '{1'b0, ALU_ADD, 32'd2,        32'd3,        32'd5,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, ALU_ADD, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
    vecs[5]  = '{1'b1, ALU_SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 3'b011,  32'hAAAA,     32'h5555,     32'd0,        1'b1, 1'b1};
    vecs[7]  = '{1'b0, ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'b101,  32'd1,        32'd1,        32'd0,        1'b1, 1'b1};
    vecs[10] = '{1'b1, ALU_OR,  32'd0,        32'd0,        32'd0,        1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].z,
                    vecs[i].zero, vecs[i].err, $sformatf("vec%0d", i));
    end

    // Response backpressure with a competing request waiting.
    @(negedge clk);
    ch0.rsp_ready = 1'b0;
    ch0.req_valid = 1'b1; ch0.a = 32'd3; ch0.b = 32'd4; ch0.op = ALU_ADD;
    #1;
    checkOutput("bp ready0", 32'(ch0.req_ready), 32'd1);
    @(posedge clk); #1;
    ch0.req_valid = 1'b0;
    ch1.req_valid = 1'b1; ch1.a = 32'd10; ch1.b = 32'd4; ch1.op = ALU_SUB;
    @(negedge clk);
    checkOutput("bp exec ready1", 32'(ch1.req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp hold rsp0_valid %0d", k), 32'(ch0.rsp_valid), 32'd1);
      checkOutput($sformatf("bp hold z %0d", k), ch0.z, 32'd7);
      checkOutput($sformatf("bp hold ready1 %0d", k), 32'(ch1.req_ready), 32'd0);
    end
    @(negedge clk);
    ch0.rsp_ready = 1'b1;
    #1;
    checkOutput("bp release ready1", 32'(ch1.req_ready), 32'd0);
    checkOutput("bp release rsp0_valid", 32'(ch0.rsp_valid), 32'd1);
    @(negedge clk);
    checkOutput("bp after ready1", 32'(ch1.req_ready), 32'd1);
    checkOutput("bp after rsp0_valid", 32'(ch0.rsp_valid), 32'd0);
    @(posedge clk); #1;
    ch1.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp rsp1_valid", 32'(ch1.rsp_valid), 32'd1);
    checkOutput("bp rsp1 z", ch1.z, 32'd6);
    @(posedge clk); #1;

    // Reset while the operation is in EXEC: result registers still hold 6.
    @(negedge clk);
    ch0.req_valid = 1'b1; ch0.a = 32'd1; ch0.b = 32'd1; ch0.op = ALU_ADD;
    @(posedge clk); #1;
    ch0.req_valid = 1'b0;
    #1;
    checkOutput("mid exec busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset rsp0_valid", 32'(ch0.rsp_valid), 32'd0);
    checkOutput("mid reset z", ch0.z, 32'd0);
    checkOutput("mid reset zero", 32'(ch0.zero), 32'd0);
    checkOutput("mid reset err", 32'(ch0.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post reset stale %0d", k), 32'({busy, ch1.rsp_valid, ch0.rsp_valid}),
                  32'd0);
    end
    applyStimulus(1'b0, ALU_SUB, 32'd20, 32'd5, 32'd15, 1'b0, 1'b0, "post reset sub");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
